// File: rtl/mips_instr_encoder_pkg.sv
// rtl/mips_instr_encoder_pkg.sv - shared types and constants for the MIPS instruction encoder
// Purpose: op-select enum, MIPS opcode/func constants and encoder FSM state enum.
// Ports: none (package enc_pkg).
package enc_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_SLT = 4'd4,
    OP_LW  = 4'd5,
    OP_SW  = 4'd6,
    OP_BEQ = 4'd7
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mips_instr_encoder_instr_pack.sv
// rtl/mips_instr_encoder_instr_pack.sv - combinational symbolic-instruction to MIPS word packer
// Purpose: packs op class and register/immediate fields into one 32-bit MIPS word.
// Ports: op[3:0], rs/rt/rd[4:0], imm[15:0] in; word[31:0], invalid (op 8..15) out.
module instr_pack
  import enc_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        invalid
);

  always_comb begin
    word    = '0;
    invalid = 1'b0;
    case (op)
      OP_ADD:  word = {OPC_RTYPE, rs, rt, rd, 5'b0, FN_ADD};
      OP_SUB:  word = {OPC_RTYPE, rs, rt, rd, 5'b0, FN_SUB};
      OP_AND:  word = {OPC_RTYPE, rs, rt, rd, 5'b0, FN_AND};
      OP_OR:   word = {OPC_RTYPE, rs, rt, rd, 5'b0, FN_OR};
      OP_SLT:  word = {OPC_RTYPE, rs, rt, rd, 5'b0, FN_SLT};
      OP_LW:   word = {OPC_LW, rs, rt, imm};
      OP_SW:   word = {OPC_SW, rs, rt, imm};
      OP_BEQ:  word = {OPC_BEQ, rs, rt, imm};
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - streaming symbolic-instruction encoder writing MIPS words to imem
// Purpose: accepts instructions over valid/ready, encodes them and writes them sequentially
//   into instruction memory from a programmed base address. Optional macro ENC_CHECKSUM_EN
//   adds a running XOR checksum output of all words written in the session.
// Ports: clk, reset (sync, active-high); start/base_addr session control; in_valid/in_ready,
//   in_op/in_rs/in_rt/in_rd/in_imm/in_last instruction stream; imem_we/imem_addr/imem_wdata
//   write port; busy, done, overflow, err, word_count status; checksum (ENC_CHECKSUM_EN only).
module mips_instr_encoder
  import enc_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [15:0]   in_imm,
  input  logic          in_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [DW-1:0] imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic          err,
  output logic [AW:0]   word_count
`ifdef ENC_CHECKSUM_EN
  ,
  output logic [DW-1:0] checksum
`endif
);

  if (DW != 32) begin : g_bad_dw
    $error("mips_instr_encoder: DW must be 32");
  end

  localparam logic [AW-1:0] ADDR_MAX = '1;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic          pend_q;
  logic [DW-1:0] word_q;
  logic [AW:0]   cnt_q;
  logic          ovf_q;
  logic          err_q;
  logic [31:0]   pk_word;
  logic          pk_invalid;
  logic          accept;
  logic          last_slot;
  logic [AW-1:0] tgt_addr;

  instr_pack u_pack (
    .op      (in_op),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .imm     (in_imm),
    .word    (pk_word),
    .invalid (pk_invalid)
  );

  assign accept = in_valid & in_ready;

  // Address the word accepted now will be written to: a write still in flight this
  // cycle advances addr_q first.
  assign tgt_addr  = addr_q + AW'(pend_q);
  assign last_slot = accept & ~pk_invalid & (tgt_addr == ADDR_MAX);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (accept && (in_last || last_slot)) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: busy     = 1'b0;
      ST_RUN:  in_ready = 1'b1;
      ST_DONE: done     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      pend_q <= 1'b0;
      word_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= accept & ~pk_invalid;
      if (accept && !pk_invalid) word_q <= pk_word;
      if (accept && pk_invalid) err_q <= 1'b1;
      if (pend_q) begin
        cnt_q <= cnt_q + (AW+1)'(1);
        // The top word is the last one ever written; addr_q parks there instead of wrapping.
        if (addr_q == ADDR_MAX) ovf_q <= 1'b1;
        else                    addr_q <= addr_q + AW'(1);
      end
      if (state_q == ST_IDLE && start) begin
        addr_q <= base_addr;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
        err_q  <= 1'b0;
      end
    end
  end

`ifdef ENC_CHECKSUM_EN
  logic [DW-1:0] csum_q;
  always_ff @(posedge clk) begin
    if (reset)                            csum_q <= '0;
    else if (state_q == ST_IDLE && start) csum_q <= '0;
    else if (pend_q)                      csum_q <= csum_q ^ word_q;
  end
  assign checksum = csum_q;
`endif

  assign imem_we    = pend_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = word_q;
  assign overflow   = ovf_q;
  assign err        = err_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb/tb_mips_instr_encoder.sv - self-checking bench for mips_instr_encoder
// Purpose: directed and randomized sessions against a list-based reference model.
// Ports: none.
module tb_mips_instr_encoder;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_ready, in_last;
  logic [AW-1:0] base_addr, imem_addr;
  logic [3:0]    in_op;
  logic [4:0]    in_rs, in_rt, in_rd;
  logic [15:0]   in_imm;
  logic          imem_we, busy, done, overflow, err;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;
`ifdef ENC_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  always #5 clk = ~clk;

  mips_instr_encoder #(.AW(AW), .DW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .err        (err),
    .word_count (word_count)
`ifdef ENC_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  logic [3:0]  s_op[$];
  logic [4:0]  s_rs[$], s_rt[$], s_rd[$];
  logic [15:0] s_imm[$];
  bit          s_last[$];
  logic [31:0] pin[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference encoding built from the MIPS field layout with plain shifts.
  function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [15:0] imm);
    logic [5:0] fn [5];
    logic [5:0] opc;
    fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    if (op < 4'd5)
      return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn[op]);
    opc = (op == 4'd5) ? 6'h23 : (op == 4'd6) ? 6'h2B : 6'h04;
    return (32'(opc) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
  endfunction

  task automatic clear_session();
    s_op.delete(); s_rs.delete(); s_rt.delete(); s_rd.delete(); s_imm.delete(); s_last.delete();
    pin.delete();
  endtask

  task automatic add_instr(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [15:0] imm, input bit last);
    s_op.push_back(op); s_rs.push_back(rs); s_rt.push_back(rt); s_rd.push_back(rd);
    s_imm.push_back(imm); s_last.push_back(last);
  endtask

  task automatic gen_random(input int n, input bit with_last, output int nvalid);
    logic [3:0] op;
    nvalid = 0;
    clear_session();
    for (int i = 0; i < n; i++) begin
      if (i != 0 && $urandom_range(0, 5) == 0) op = 4'(8 + $urandom_range(0, 7));
      else                                     op = 4'($urandom_range(0, 7));
      if (op < 4'd8) nvalid++;
      add_instr(op, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), with_last && (i == n - 1));
    end
  endtask

  task automatic drive_idle_fields();
    in_valid = 1'b0;
    in_op = 4'($urandom); in_rs = 5'($urandom); in_rt = 5'($urandom);
    in_rd = 5'($urandom); in_imm = 16'($urandom); in_last = 1'($urandom);
  endtask

  task automatic run_session(input logic [AW-1:0] base, input bit gaps);
    logic [7:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] exp_sum, d;
    int          a, n_acc_exp, n_wr_exp, idx, n_acc, cyc;
    bit          exp_err, exp_ovf, pend_exp, got_done, will_acc;

    a = int'(base); n_acc_exp = 0; n_wr_exp = 0; exp_err = 0; exp_ovf = 0; exp_sum = '0;
    for (int i = 0; i < s_op.size(); i++) begin
      n_acc_exp++;
      if (s_op[i] >= 4'd8) exp_err = 1;
      else begin
        d = enc(s_op[i], s_rs[i], s_rt[i], s_rd[i], s_imm[i]);
        exp_addr.push_back(a[7:0]); exp_data.push_back(d); exp_sum ^= d; n_wr_exp++;
        if (a == 255) begin exp_ovf = 1; break; end
        a++;
      end
      if (s_last[i]) break;
    end

    @(negedge clk);
    start = 1'b1; base_addr = base;
    @(negedge clk);
    start = 1'b0; base_addr = 8'($urandom);
    idx = 0; n_acc = 0; cyc = 0; pend_exp = 0; got_done = 0;
    while (!got_done && cyc < 300) begin
      check("we", 32'(imem_we), 32'(pend_exp));
      if (imem_we) begin
        if (exp_addr.size() > 0) begin
          check("addr", 32'(imem_addr), 32'(exp_addr.pop_front()));
          check("data", imem_wdata, exp_data.pop_front());
        end else check("extra_write", 32'(imem_we), 32'(0));
        if (pin.size() > 0) check("pinned_data", imem_wdata, pin.pop_front());
      end
      if (done) got_done = 1;
      else begin
        if (idx < s_op.size() && (!gaps || $urandom_range(0, 3) != 0)) begin
          in_valid = 1'b1; in_op = s_op[idx]; in_rs = s_rs[idx]; in_rt = s_rt[idx];
          in_rd = s_rd[idx]; in_imm = s_imm[idx]; in_last = s_last[idx];
        end else drive_idle_fields();
        will_acc = in_valid && in_ready;
        pend_exp = will_acc && (in_op < 4'd8);
        if (will_acc) begin idx++; n_acc++; end
        @(negedge clk);
        cyc++;
      end
    end
    drive_idle_fields();
    check("done_seen", 32'(got_done), 32'(1));
    check("accepted", 32'(n_acc), 32'(n_acc_exp));
    check("leftover_writes", 32'(exp_addr.size()), 32'(0));
    check("word_count", 32'(word_count), 32'(n_wr_exp));
    check("err", 32'(err), 32'(exp_err));
    check("overflow", 32'(overflow), 32'(exp_ovf));
`ifdef ENC_CHECKSUM_EN
    check("checksum", checksum, exp_sum);
`endif
    @(negedge clk);
    check("done_pulse", 32'(done), 32'(0));
    check("idle_busy", 32'(busy), 32'(0));
    check("hold_count", 32'(word_count), 32'(n_wr_exp));
  endtask

  int nv, k;

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0;
    drive_idle_fields();
    repeat (3) @(negedge clk);
    check("rst_we", 32'(imem_we), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ready", 32'(in_ready), 32'(0));
    check("rst_flags", 32'({done, overflow, err}), 32'(0));
    check("rst_count", 32'(word_count), 32'(0));
    check("rst_data", imem_wdata, 32'(0));
    reset = 1'b0;

    // Single ADD with last.
    clear_session();
    add_instr(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1);
    pin.push_back(32'h00221820);
    run_session(8'h10, 0);

    // LW / SW / BEQ back-to-back.
    clear_session();
    add_instr(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 0);
    add_instr(4'd6, 5'd0,  5'd9, 5'd0, 16'h0008, 0);
    add_instr(4'd7, 5'd1,  5'd2, 5'd0, 16'hFFFF, 1);
    pin.push_back(32'h8FA80004); pin.push_back(32'hAC090008); pin.push_back(32'h1022FFFF);
    run_session(8'h20, 0);
`ifdef ENC_CHECKSUM_EN
    check("checksum_pinned", checksum, 32'h8FA80004 ^ 32'hAC090008 ^ 32'h1022FFFF);
`endif

    // Invalid op between two ADDs.
    clear_session();
    add_instr(4'd0, 5'd4, 5'd5, 5'd6, 16'h0, 0);
    add_instr(4'd12, 5'd7, 5'd7, 5'd7, 16'h1234, 0);
    add_instr(4'd0, 5'd8, 5'd9, 5'd10, 16'h0, 1);
    run_session(8'h30, 0);

    // Address exhaustion: three valid, no last, base two below top.
    clear_session();
    add_instr(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 0);
    add_instr(4'd4, 5'd4, 5'd5, 5'd6, 16'h0, 0);
    add_instr(4'd3, 5'd7, 5'd8, 5'd9, 16'h0, 0);
    run_session(8'hFE, 1);

    // Invalid op as the last beat.
    clear_session();
    add_instr(4'd2, 5'd1, 5'd1, 5'd1, 16'h0, 0);
    add_instr(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 1);
    run_session(8'h00, 1);

    // Reset with a write pending; start ignored while busy.
    @(negedge clk);
    start = 1'b1; base_addr = 8'h40;
    @(negedge clk);
    start = 1'b1; base_addr = 8'h80;
    in_valid = 1'b1; in_op = 4'd0; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_last = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("mid_we", 32'(imem_we), 32'(1));
    check("mid_addr", 32'(imem_addr), 32'h40);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_we", 32'(imem_we), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_ready", 32'(in_ready), 32'(0));
    check("mid_rst_addr", 32'(imem_addr), 32'(0));
    check("mid_rst_data", imem_wdata, 32'(0));
    check("mid_rst_count", 32'(word_count), 32'(0));
    reset = 1'b0;
    drive_idle_fields();

    // Random sessions ending with last.
    for (int s = 0; s < 20; s++) begin
      gen_random($urandom_range(1, 10), 1, nv);
      run_session(8'($urandom), 1);
    end

    // Random sessions ending by exhaustion.
    for (int s = 0; s < 6; s++) begin
      gen_random(8, 0, nv);
      k = $urandom_range(1, (nv < 3) ? nv : 3);
      run_session(8'(256 - k), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
Streaming instruction encoder: accepts symbolic instructions (op class, register fields, imm16) over a valid/ready handshake and packs them into 32-bit MIPS words. Words are written sequentially into instruction memory starting at a programmed base address.
Sits between the test/program loader and the imem write port. It is the inverse of the main control decoder: its output words decode back to the same control signals.
Supports exactly ADD, SUB, AND, OR, SLT, LW, SW, BEQ.

Parameters:
AW, 8, imem word-address width
DW, 32, instruction word width (fixed 32; any other value illegal)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begin session (ignored unless IDLE)
base_addr  input  AW  first imem word address, sampled on start
in_valid  input  1  instruction fields valid
in_ready  output  1  encoder accepts this cycle
in_op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8–15 invalid
in_rs  input  5  rs field
in_rt  input  5  rt field
in_rd  input  5  rd field (R-type only)
in_imm  input  16  immediate (I-type only)
in_last  input  1  final instruction of session
imem_we  output  1  write strobe, one cycle per word
imem_addr  output  AW  write address
imem_wdata  output  32  encoded word
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at session end
overflow  output  1  sticky: session ended by address exhaustion
err  output  1  sticky: at least one invalid op dropped
word_count  output  AW+1  words written this session

Behaviour:
- Reset (synchronous, active-high, takes priority over all inputs, including mid-session): state IDLE; all outputs 0; pending write discarded.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - in_ready=0.
  - start → RUN; addr_q<=base_addr; word_count, overflow, err, checksum cleared.
- RUN:
  - in_ready=1.
  - Handshake fires when in_valid & in_ready.
  - Accepted valid op: word registered; next cycle imem_we=1, imem_addr=addr_q, imem_wdata=word. Latency is exactly 1 cycle.
  - After each write: addr_q increments, word_count increments.
  - Back-to-back accepts give back-to-back writes; throughput 1 word/cycle.
- Encoding:
  - R-type: {6'b000000, rs, rt, rd, 5'b0, func}; func ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - LW: {100011, rs, rt, imm}.
  - SW: {101011, rs, rt, imm}.
  - BEQ: {000100, rs, rt, imm}.
  - Unused fields ignored (rd for I-type, imm for R-type).
- Invalid op (8–15): accepted, no write, err set sticky, address not advanced.
- in_last accepted → FLUSH. The in_last beat is written if valid; if it carries an invalid op, nothing is written.
- Address exhaustion: a write at addr_q = 2^AW−1 sets overflow → FLUSH. in_ready drops the cycle after that accept; no wrap-around write ever occurs.
- FLUSH: in_ready=0; completes the pending write → DONE.
- DONE: done=1 for one cycle → IDLE. overflow, err and word_count hold until the next start.
- start while busy: ignored.
- Simultaneous in_last and exhaustion: single FLUSH; overflow=1.

Optional Feature:
ENC_CHECKSUM_EN.
- Defined: adds output checksum [31:0], the running XOR of all words written this session. Cleared on start and on reset; valid when done pulses.
- Undefined: port absent, no logic.

Decomposition:
- Shared package enc_pkg holds:
  - op-select enum (OP_ADD..OP_BEQ);
  - opcode constants OPC_RTYPE 6'h00, OPC_LW 6'h23, OPC_SW 6'h2B, OPC_BEQ 6'h04;
  - func constants FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT;
  - FSM state enum.
- One sub-module, instr_pack: combinational fields → {word, invalid}. The parent holds the FSM, registers, address counter and flags.

Test Plan:
- reset; start base=0x10; ADD rs=1 rt=2 rd=3, in_last → 1 cycle later imem_we, addr 0x10, data 0x00221820; done next cycle; word_count=1.
- Stream LW rt=8 rs=29 imm=4; SW rt=9 rs=0 imm=8; BEQ rs=1 rt=2 imm=0xFFFF(last), all back-to-back → writes 0x8FA80004 @base, 0xAC090008 @base+1, 0x1022FFFF @base+2 on consecutive cycles.
- Invalid op 12 between two ADDs → two writes at consecutive addresses; err=1; word_count=2.
- base=2^AW−2, three valid instructions, no last → two writes; overflow=1; in_ready=0 thereafter; third not accepted; done pulses.
- reset asserted mid-stream with a write pending → no imem_we the next cycle; all outputs 0; start ignored while busy.
- ENC_CHECKSUM_EN: words from scenario 2 → checksum = 0x8FA80004^0xAC090008^0x1022FFFF at done.
